// File: rtl/fir_stream_arbiter_if.sv
// AXI-Stream bundle shared by every port of fir_stream_arbiter.
//   tdata  : sample word
//   tvalid : producer has a beat
//   tlast  : last beat of a packet
//   tready : consumer accepts the beat
// master drives tdata/tvalid/tlast, slave drives tready.
interface fir_stream_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fir_stream_arbiter.sv
// Shares one FIR filter between two AXI-Stream sources. Whole packets are
// granted round-robin; the owner of each granted packet is queued in a tag
// FIFO so the filter's output packets can be steered back to the right sink.
//
// Ports:
//   s00_axis_aclk    : clock for every stream
//   s00_axis_aresetn : async active-low reset
//   s00_axis (slave) : channel 0 source samples
//   s01_axis (slave) : channel 1 source samples
//   m00_axis (master): to filter input
//   s02_axis (slave) : filter output (already scaled)
//   m01_axis (master): channel 0 filtered result
//   m02_axis (master): channel 1 filtered result
//
// Grant FSM:
//   state | meaning
//   IDLE  | arbitration cycle, no source connected to the filter
//   GNT0  | channel 0 packet passes through to the filter
//   GNT1  | channel 1 packet passes through to the filter
module fir_stream_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 4
) (
  input logic                  s00_axis_aclk,
  input logic                  s00_axis_aresetn,
  fir_stream_arbiter_if.slave  s00_axis,
  fir_stream_arbiter_if.slave  s01_axis,
  fir_stream_arbiter_if.master m00_axis,
  fir_stream_arbiter_if.slave  s02_axis,
  fir_stream_arbiter_if.master m01_axis,
  fir_stream_arbiter_if.master m02_axis
);

  localparam int AW    = $clog2(TAG_DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           state, next_state;
  logic             last_served, next_last_served;
  logic             push, pop, grant_ch;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             tag_mem [TAG_DEPTH];
  logic             fifo_full, fifo_empty, head_tag;

  logic [DATA_WIDTH-1:0] src_tdata;
  logic                  src_tlast, src_tvalid;
  logic                  s00_rdy, s01_rdy;
  logic                  ret_ready;

  assign fifo_full  = (count == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (count == '0);
  assign head_tag   = tag_mem[rd_ptr];

  // state register
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      state       <= next_state;
      last_served <= next_last_served;
    end
  end

  // next-state logic; the tag push happens on the edge leaving IDLE
  always_comb begin
    next_state       = state;
    next_last_served = last_served;
    push             = 1'b0;
    grant_ch         = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_full && (s00_axis.tvalid || s01_axis.tvalid)) begin
          if (s00_axis.tvalid && s01_axis.tvalid) begin
            grant_ch         = ~last_served;
            next_last_served = ~last_served;
          end else begin
            grant_ch = s01_axis.tvalid;
          end
          push       = 1'b1;
          next_state = grant_ch ? GNT1 : GNT0;
        end
      end
      GNT0: if (s00_axis.tvalid && m00_axis.tready && s00_axis.tlast) next_state = IDLE;
      GNT1: if (s01_axis.tvalid && m00_axis.tready && s01_axis.tlast) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // outputs: zero-latency passthrough of the granted source
  always_comb begin
    src_tdata  = s00_axis.tdata;
    src_tlast  = s00_axis.tlast;
    src_tvalid = 1'b0;
    s00_rdy    = 1'b0;
    s01_rdy    = 1'b0;
    case (state)
      GNT0: begin
        src_tvalid = s00_axis.tvalid;
        s00_rdy    = m00_axis.tready;
      end
      GNT1: begin
        src_tdata  = s01_axis.tdata;
        src_tlast  = s01_axis.tlast;
        src_tvalid = s01_axis.tvalid;
        s01_rdy    = m00_axis.tready;
      end
      default: ;
    endcase
  end

  assign m00_axis.tdata  = src_tdata;
  assign m00_axis.tlast  = src_tlast;
  assign m00_axis.tvalid = src_tvalid;
  assign s00_axis.tready = s00_rdy;
  assign s01_axis.tready = s01_rdy;

  // return path steered by the FIFO head tag
  assign ret_ready       = !fifo_empty && (head_tag ? m02_axis.tready : m01_axis.tready);
  assign s02_axis.tready = ret_ready;
  assign m01_axis.tvalid = !fifo_empty && !head_tag && s02_axis.tvalid;
  assign m02_axis.tvalid = !fifo_empty &&  head_tag && s02_axis.tvalid;
  assign m01_axis.tdata  = s02_axis.tdata;
  assign m01_axis.tlast  = s02_axis.tlast;
  assign m02_axis.tdata  = s02_axis.tdata;
  assign m02_axis.tlast  = s02_axis.tlast;

  assign pop = s02_axis.tvalid && ret_ready && s02_axis.tlast;

  // tag FIFO pointers; TAG_DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // storage is only read when count says the entry is live, so no reset
  always_ff @(posedge s00_axis_aclk) begin
    if (push) tag_mem[wr_ptr] <= grant_ch;
  end

endmodule

// File: doc/fir_stream_arbiter.md
Name: fir_stream_arbiter

Overview:
- Shares one axis_fir_15 filter instance between two independent AXI-Stream sample sources (e.g. I and Q).
- Arbitrates at packet granularity (tlast-delimited) with round-robin fairness.
- Records the owner of each packet in a tag FIFO, then routes the filter's output packets back to the matching consumer.
- Sits between the sources and the filter/scaler path, and between that path and the downstream DMA ports.

Parameters:
- DATA_WIDTH, 32, width of every tdata bus in and out.
- TAG_DEPTH, 4, maximum packets granted to the filter but not yet fully returned; must be a power of two, at least 2.

Ports:
- s00_axis_aclk  in  1  single clock for all interfaces
- s00_axis_aresetn  in  1  reset, asynchronous, active-low
- s00_axis_tdata  in  DATA_WIDTH  channel 0 source samples
- s00_axis_tvalid  in  1  channel 0 source valid
- s00_axis_tlast  in  1  channel 0 end of packet
- s00_axis_tready  out  1  channel 0 source ready
- s01_axis_tdata  in  DATA_WIDTH  channel 1 source samples
- s01_axis_tvalid  in  1  channel 1 source valid
- s01_axis_tlast  in  1  channel 1 end of packet
- s01_axis_tready  out  1  channel 1 source ready
- m00_axis_tdata  out  DATA_WIDTH  to filter input
- m00_axis_tvalid  out  1  to filter input
- m00_axis_tlast  out  1  to filter input
- m00_axis_tready  in  1  from filter input
- s02_axis_tdata  in  DATA_WIDTH  filter output (already scaled)
- s02_axis_tvalid  in  1  filter output valid
- s02_axis_tlast  in  1  filter output end of packet
- s02_axis_tready  out  1  filter output ready
- m01_axis_tdata  out  DATA_WIDTH  channel 0 filtered result
- m01_axis_tvalid  out  1  channel 0 result valid
- m01_axis_tlast  out  1  channel 0 result end of packet
- m01_axis_tready  in  1  channel 0 result ready
- m02_axis_tdata  out  DATA_WIDTH  channel 1 filtered result
- m02_axis_tvalid  out  1  channel 1 result valid
- m02_axis_tlast  out  1  channel 1 result end of packet
- m02_axis_tready  in  1  channel 1 result ready

Behaviour:
- Reset state:
  - Grant FSM in IDLE; last_served = 1, so channel 0 wins the first tie.
  - Tag FIFO empty.
  - Every tvalid and tready output is 0. tdata/tlast outputs are don't-care while tvalid is 0.
- Grant FSM states: IDLE, GNT0, GNT1 (registered).
- IDLE transition rules:
  - If the tag FIFO is not full and at least one source tvalid is high, go to the chosen GNTn and push tag n in the same edge.
  - If both sources are valid, choose the channel != last_served; set last_served to the chosen channel.
  - If the FIFO is full, stay in IDLE; source treadys stay 0.
- GNTn (combinational passthrough, zero added latency):
  - m00 tdata/tlast = source n; m00_axis_tvalid = sn tvalid; sn tready = m00_axis_tready.
  - The other source's tready = 0.
  - On a handshake with tlast=1, return to IDLE.
- Cost of arbitration: exactly one idle bubble cycle per packet (the IDLE cycle). Back-to-back packets from a single source are therefore spaced by at least 1 cycle.
- Return path (combinational on the FIFO head tag h):
  - If the FIFO is empty: s02_axis_tready = 0, m01/m02 tvalid = 0.
  - Otherwise: m0(h+1) tvalid = s02_axis_tvalid; s02_axis_tready = m0(h+1) tready; the other master's tvalid = 0; tdata/tlast are forwarded to both masters.
  - Pop the FIFO on a return handshake with s02_axis_tlast=1.
- Push and pop on the same edge: both take effect and occupancy is unchanged. A push when full is impossible by construction. A pop when empty is impossible because tready is 0.
- Ordering: the filter preserves packet order, so the return stream is assumed to match tag order. No reordering support.
- Asserting reset mid-packet: FSM, FIFO and pointers clear immediately (async). Partial packets are abandoned; upstream and filter are reset by the same signal.
- Occupancy counter width: clog2(TAG_DEPTH)+1. Read and write pointers wrap modulo TAG_DEPTH.

Test Plan:
- Single source: ch0 sends 3 packets of 8 beats, filter model returns identical packets.
  - Required: 24 beats on m01, m02_axis_tvalid never 1.
  - Required: one bubble between packets on m00; tlast on beats 8, 16, 24.
- Contention: both sources valid continuously, 4-beat packets.
  - Required: m00 carries ch0, ch1, ch0, ch1 packets in that order.
  - Required: each result emerges on the matching m01/m02 with tdata intact.
- Tag FIFO full: filter model stalls its output (s02_axis_tvalid=0) after TAG_DEPTH=4 packets granted.
  - Required: 5th packet not granted, both source treadys stay 0.
  - Required: one return packet completes -> grant resumes on the next cycle.
- Backpressure: m02_axis_tready held 0 for 10 cycles while its packet is at the FIFO head.
  - Required: s02_axis_tready = 0 over those 10 cycles, m01 receives nothing.
  - Required: release -> beats resume with no loss or duplication.
- Simultaneous push/pop: the last return beat (tlast) of packet A and the IDLE grant of packet B land on the same edge.
  - Required: occupancy is unchanged, and B's tag is correct at the head later.
- Reset mid-packet: assert s00_axis_aresetn low on beat 3 of a 6-beat ch1 packet.
  - Required: all tvalid/tready = 0 within the same cycle, FIFO empty.
  - Required: after release, ch0 wins the first tie.
